// File: rtl/dmem_arbiter_if.sv
// One requester's view of the data-memory arbiter.
// The requester (master) drives the request fields.
// The arbiter (slave) returns the grant and the one-cycle-later response.
//   req/we/addr/wdata/size/is_unsigned : request, held until gnt
//   gnt                                : access accepted this cycle (combinational)
//   rvalid/rdata/err                   : registered response, one cycle after gnt
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        is_unsigned;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, size, is_unsigned,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, size, is_unsigned,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for the byte-addressed data memory.
// Port 0 is the core LSU. Port 1 is a secondary master that may lock the memory for bursts.
// The burst length is bounded by MAX_LOCK while port 0 waits.
// Illegal accesses are granted but never reach memory; they return err.
//   clk, rst         : clock, synchronous active-high reset
//   p0, p1           : requester interfaces (slave side)
//   p1_lock          : port 1 asks to keep ownership next cycle
//   mem_*            : combinational memory request; mem_dataR is the read data
module dmem_arbiter #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned MAX_LOCK    = 8
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    input  logic          p1_lock,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_dataW,
    output logic          mem_MemRW,
    output logic [1:0]    mem_MemSize,
    output logic          mem_MemUnsigned,
    input  logic [31:0]   mem_dataR
);

    localparam int unsigned    CntW   = $clog2(MAX_LOCK + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_LOCK);

    logic            last_gnt_q, last_gnt_d;
    logic            lock_owner_q, lock_owner_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic            err0_q, err0_d, err1_q, err1_d;
    logic [31:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic        gnt0, gnt1, any_gnt, lock_win, legal;
    logic        w_we, w_uns;
    logic [31:0] w_addr, w_wdata;
    logic [1:0]  w_size;

    // Size, alignment and range check; the end address is formed in 33 bits so it cannot wrap.
    function automatic logic access_legal(input logic [31:0] addr, input logic [1:0] size);
        logic [2:0]  nbytes;
        logic        aligned;
        logic [32:0] end_addr;
        nbytes  = 3'd4;
        aligned = 1'b0;
        case (size)
            2'b00:   begin nbytes = 3'd1; aligned = 1'b1;               end
            2'b01:   begin nbytes = 3'd2; aligned = ~addr[0];           end
            2'b10:   begin nbytes = 3'd4; aligned = (addr[1:0] == 2'b00); end
            default: begin nbytes = 3'd4; aligned = 1'b0;               end
        endcase
        end_addr = {1'b0, addr} + {30'd0, nbytes};
        return aligned && (end_addr <= 33'(DEPTH_BYTES));
    endfunction

    // Arbitration: an active lock wins first, then a lone requester, then round-robin.
    assign lock_win = lock_owner_q & p1.req & (lock_cnt_q < MaxCnt);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (lock_win) begin
            gnt1 = 1'b1;
        end else if (p0.req && !p1.req) begin
            gnt0 = 1'b1;
        end else if (p1.req && !p0.req) begin
            gnt1 = 1'b1;
        end else if (p0.req && p1.req) begin
            gnt0 = last_gnt_q;
            gnt1 = ~last_gnt_q;
        end
    end

    assign any_gnt = gnt0 | gnt1;
    assign p0.gnt  = gnt0;
    assign p1.gnt  = gnt1;

    // Winner's request fields
    assign w_we    = gnt1 ? p1.we          : p0.we;
    assign w_uns   = gnt1 ? p1.is_unsigned : p0.is_unsigned;
    assign w_addr  = gnt1 ? p1.addr        : p0.addr;
    assign w_wdata = gnt1 ? p1.wdata       : p0.wdata;
    assign w_size  = gnt1 ? p1.size        : p0.size;
    assign legal   = any_gnt & access_legal(w_addr, w_size);

    // Idle and rejected cycles present a harmless word read of address 0.
    always_comb begin
        mem_addr        = 32'd0;
        mem_dataW       = 32'd0;
        mem_MemRW       = 1'b0;
        mem_MemSize     = 2'b10;
        mem_MemUnsigned = 1'b0;
        if (legal) begin
            mem_addr        = w_addr;
            mem_dataW       = w_wdata;
            mem_MemRW       = w_we & ~rst;
            mem_MemSize     = w_size;
            mem_MemUnsigned = w_uns;
        end
    end

    // Next-state for arbitration, lock and response registers
    always_comb begin
        last_gnt_d   = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_gnt_q);
        lock_owner_d = gnt1 & p1_lock;

        lock_cnt_d = lock_cnt_q;
        if (gnt0 || (lock_owner_q && !lock_owner_d)) begin
            lock_cnt_d = '0;
        end else if (gnt1 && lock_owner_q && p0.req && (lock_cnt_q < MaxCnt)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end

        rvalid0_d = gnt0;
        rvalid1_d = gnt1;
        err0_d    = gnt0 & ~legal;
        err1_d    = gnt1 & ~legal;
        rdata0_d  = (gnt0 && legal && !w_we) ? mem_dataR : 32'd0;
        rdata1_d  = (gnt1 && legal && !w_we) ? mem_dataR : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q   <= 1'b1;
            lock_owner_q <= 1'b0;
            lock_cnt_q   <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign p0.rvalid = rvalid0_q;
    assign p0.err    = err0_q;
    assign p0.rdata  = rdata0_q;
    assign p1.rvalid = rvalid1_q;
    assign p1.err    = err1_q;
    assign p1.rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array memory model (little-endian,
// with sign/zero extension done by the model, as the real memory does).
module tb_dmem_arbiter;

    localparam int unsigned DEPTH = 1024;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
    } port_in_t;

    typedef struct {
        port_in_t    a;
        port_in_t    b;
        logic        g0;
        logic        g1;
        logic        rw;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic        e0;
        logic        e1;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        p1_lock;
    logic [31:0] mem_addr, mem_dataW, mem_dataR;
    logic        mem_MemRW, mem_MemUnsigned;
    logic [1:0]  mem_MemSize;

    int checks = 0;
    int errors = 0;

    dmem_arbiter_if p0_if ();
    dmem_arbiter_if p1_if ();

    dmem_arbiter #(
        .DEPTH_BYTES(DEPTH),
        .MAX_LOCK   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .p0             (p0_if),
        .p1             (p1_if),
        .p1_lock        (p1_lock),
        .mem_addr       (mem_addr),
        .mem_dataW      (mem_dataW),
        .mem_MemRW      (mem_MemRW),
        .mem_MemSize    (mem_MemSize),
        .mem_MemUnsigned(mem_MemUnsigned),
        .mem_dataR      (mem_dataR)
    );

    always #5 clk = ~clk;

    // Memory model
    logic [7:0] mem [DEPTH];
    logic [9:0] ra;
    logic [7:0] b0, b1, b2, b3;
    assign ra = mem_addr[9:0];

    always_comb begin
        b0 = mem[ra];
        b1 = mem[ra + 10'd1];
        b2 = mem[ra + 10'd2];
        b3 = mem[ra + 10'd3];
        case (mem_MemSize)
            2'b00:   mem_dataR = mem_MemUnsigned ? {24'd0, b0} : {{24{b0[7]}}, b0};
            2'b01:   mem_dataR = mem_MemUnsigned ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: mem_dataR = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (mem_MemRW) begin
            mem[ra] <= mem_dataW[7:0];
            if (mem_MemSize != 2'b00) mem[ra + 10'd1] <= mem_dataW[15:8];
            if (mem_MemSize == 2'b10) begin
                mem[ra + 10'd2] <= mem_dataW[23:16];
                mem[ra + 10'd3] <= mem_dataW[31:24];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic port_in_t pi(input logic req, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [1:0] size,
                                    input logic uns);
        port_in_t p;
        p.req = req; p.we = we; p.addr = addr; p.wdata = wdata; p.size = size; p.uns = uns;
        return p;
    endfunction

    function automatic vec_t mk(input port_in_t a, input port_in_t b, input logic g0,
                                input logic g1, input logic rw, input logic [31:0] addr,
                                input logic [1:0] sz, input logic e0, input logic e1,
                                input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.a = a; v.b = b; v.g0 = g0; v.g1 = g1; v.rw = rw; v.addr = addr; v.sz = sz;
        v.e0 = e0; v.e1 = e1; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic drive(input port_in_t a, input port_in_t b, input logic lk);
        p0_if.req = a.req; p0_if.we = a.we; p0_if.addr = a.addr;
        p0_if.wdata = a.wdata; p0_if.size = a.size; p0_if.is_unsigned = a.uns;
        p1_if.req = b.req; p1_if.we = b.we; p1_if.addr = b.addr;
        p1_if.wdata = b.wdata; p1_if.size = b.size; p1_if.is_unsigned = b.uns;
        p1_lock = lk;
    endtask

    localparam int NV = 18;
    vec_t vecs [NV];

    initial begin
        port_in_t idle_p, p0_lw, p1_lw, p0_st50;
        logic     eg0, eg1, pg0, pg1;
        logic [31:0] m50;

        idle_p = pi(1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 1'b0);
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'd0;

        // {p0, p1, gnt0, gnt1, MemRW, mem_addr, MemSize, err0, err1, rdata0, rdata1}
        vecs[0]  = mk(pi(1,1,32'h10,32'hDEADBEEF,2,0), pi(1,1,32'h20,32'h12345678,2,0),
                      1,0,1,32'h10,2, 0,0,0,0);
        vecs[1]  = mk(idle_p, pi(1,1,32'h20,32'h12345678,2,0), 0,1,1,32'h20,2, 0,0,0,0);
        vecs[2]  = mk(pi(1,0,32'h10,0,2,0), pi(1,0,32'h20,0,2,0), 1,0,0,32'h10,2,
                      0,0,32'hDEADBEEF,0);
        vecs[3]  = mk(idle_p, pi(1,0,32'h20,0,2,0), 0,1,0,32'h20,2, 0,0,0,32'h12345678);
        vecs[4]  = mk(pi(1,0,32'h3,0,1,0), pi(1,0,32'd1022,0,2,0), 1,0,0,32'h0,2, 1,0,0,0);
        vecs[5]  = mk(idle_p, pi(1,0,32'd1022,0,2,0), 0,1,0,32'h0,2, 0,1,0,0);
        vecs[6]  = mk(pi(1,1,32'h40,32'h80,0,0), pi(1,0,32'h0,0,3,0), 1,0,1,32'h40,0,
                      0,0,0,0);
        vecs[7]  = mk(pi(1,0,32'h40,0,0,0), pi(1,0,32'h0,0,3,0), 0,1,0,32'h0,2, 0,1,0,0);
        vecs[8]  = mk(pi(1,0,32'h40,0,0,0), idle_p, 1,0,0,32'h40,0, 0,0,32'hFFFFFF80,0);
        vecs[9]  = mk(pi(1,0,32'h40,0,0,1), idle_p, 1,0,0,32'h40,0, 0,0,32'h00000080,0);
        vecs[10] = mk(idle_p, pi(1,0,32'd1020,0,2,0), 0,1,0,32'd1020,2, 0,0,0,0);
        vecs[11] = mk(pi(1,1,32'd1022,32'h0000BEEF,1,0), pi(1,1,32'h22,32'h1,2,0),
                      1,0,1,32'd1022,1, 0,0,0,0);
        vecs[12] = mk(idle_p, pi(1,1,32'h22,32'h1,2,0), 0,1,0,32'h0,2, 0,1,0,0);
        vecs[13] = mk(idle_p, idle_p, 0,0,0,32'h0,2, 0,0,0,0);
        vecs[14] = mk(pi(1,0,32'd1022,0,1,1), pi(1,0,32'd1022,0,1,0), 1,0,0,32'd1022,1,
                      0,0,32'h0000BEEF,0);
        vecs[15] = mk(idle_p, pi(1,0,32'd1022,0,1,0), 0,1,0,32'd1022,1, 0,0,0,32'hFFFFBEEF);
        vecs[16] = mk(pi(1,0,32'd1024,0,0,0), idle_p, 1,0,0,32'h0,2, 1,0,0,0);
        vecs[17] = mk(idle_p, idle_p, 0,0,0,32'h0,2, 0,0,0,0);

        // Reset
        rst = 1'b1;
        drive(idle_p, idle_p, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rvalid0", p0_if.rvalid, 0);
        check("reset_rvalid1", p1_if.rvalid, 0);
        check("reset_err0", p0_if.err, 0);
        check("reset_err1", p1_if.err, 0);
        check("reset_rdata0", p0_if.rdata, 0);
        check("reset_rdata1", p1_if.rdata, 0);
        check("idle_memsize", mem_MemSize, 2'b10);
        @(posedge clk); #1;

        // Table-driven single-cycle vectors; responses checked one cycle later
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].a, vecs[i].b, 1'b0);
            @(negedge clk);
            check($sformatf("v%0d_gnt0", i), p0_if.gnt, vecs[i].g0);
            check($sformatf("v%0d_gnt1", i), p1_if.gnt, vecs[i].g1);
            check($sformatf("v%0d_memrw", i), mem_MemRW, vecs[i].rw);
            check($sformatf("v%0d_memaddr", i), mem_addr, vecs[i].addr);
            check($sformatf("v%0d_memsize", i), mem_MemSize, vecs[i].sz);
            if (i > 0) begin
                check($sformatf("v%0d_rvalid0", i-1), p0_if.rvalid, vecs[i-1].g0);
                check($sformatf("v%0d_rvalid1", i-1), p1_if.rvalid, vecs[i-1].g1);
                if (vecs[i-1].g0) begin
                    check($sformatf("v%0d_err0", i-1), p0_if.err, vecs[i-1].e0);
                    check($sformatf("v%0d_rdata0", i-1), p0_if.rdata, vecs[i-1].rd0);
                end
                if (vecs[i-1].g1) begin
                    check($sformatf("v%0d_err1", i-1), p1_if.err, vecs[i-1].e1);
                    check($sformatf("v%0d_rdata1", i-1), p1_if.rdata, vecs[i-1].rd1);
                end
            end
            @(posedge clk); #1;
        end

        // Lock burst: p1 locks alone first, then p0 joins; 8 locked grants, one p0, p1 again.
        p0_lw = pi(1, 0, 32'h104, 0, 2, 0);
        p1_lw = pi(1, 0, 32'h100, 0, 2, 0);
        pg0 = 1'b0;
        pg1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drive((c >= 1) ? p0_lw : idle_p, p1_lw, 1'b1);
            eg0 = (c == 9) || (c == 19);
            eg1 = !eg0;
            @(negedge clk);
            check($sformatf("lock_c%0d_gnt0", c), p0_if.gnt, eg0);
            check($sformatf("lock_c%0d_gnt1", c), p1_if.gnt, eg1);
            if (c > 0) begin
                check($sformatf("lock_c%0d_rvalid0", c), p0_if.rvalid, pg0);
                check($sformatf("lock_c%0d_rvalid1", c), p1_if.rvalid, pg1);
            end
            pg0 = eg0;
            pg1 = eg1;
            @(posedge clk); #1;
        end

        // A held lock must not block port 0 once port 1 stops requesting
        drive(idle_p, p1_lw, 1'b1);
        @(negedge clk);
        check("lock_alone_gnt1", p1_if.gnt, 1);
        @(posedge clk); #1;
        drive(p0_lw, idle_p, 1'b1);
        @(negedge clk);
        check("lock_release_gnt0", p0_if.gnt, 1);
        @(posedge clk); #1;

        // Reset coincident with a granted store
        p0_st50 = pi(1, 1, 32'h50, 32'hCAFEF00D, 2, 0);
        drive(p0_st50, idle_p, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_store_gnt0", p0_if.gnt, 1);
        check("rst_store_memrw", mem_MemRW, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(idle_p, idle_p, 1'b0);
        @(negedge clk);
        check("rst_store_rvalid0", p0_if.rvalid, 0);
        m50 = {mem[32'h53], mem[32'h52], mem[32'h51], mem[32'h50]};
        check("rst_store_mem50", m50, 32'h0);
        @(posedge clk); #1;

        // First tie after reset goes to p0
        drive(pi(1, 0, 32'h50, 0, 2, 0), pi(1, 0, 32'h20, 0, 2, 0), 1'b0);
        @(negedge clk);
        check("post_rst_tie_gnt0", p0_if.gnt, 1);
        check("post_rst_tie_gnt1", p1_if.gnt, 0);
        @(posedge clk); #1;
        drive(idle_p, pi(1, 0, 32'h20, 0, 2, 0), 1'b0);
        @(negedge clk);
        check("post_rst_gnt1", p1_if.gnt, 1);
        check("post_rst_rdata0_50", p0_if.rdata, 32'h0);
        check("post_rst_rvalid0", p0_if.rvalid, 1);
        @(posedge clk); #1;
        drive(idle_p, idle_p, 1'b0);
        @(negedge clk);
        check("post_rst_rdata1_20", p1_if.rdata, 32'h12345678);
        check("post_rst_rvalid1", p1_if.rvalid, 1);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the byte-addressed data memory. Port 0 is the core load/store unit; port 1 is a secondary master such as a DMA or debug loader. The block grants at most one access per cycle using round-robin arbitration. Port 1 may lock the memory for bursts, bounded by a starvation limit. Illegal accesses are rejected before they reach memory, and each accepted access returns a registered, one-cycle-later response.

## Interface
- DEPTH_BYTES, 1024, memory size in bytes; must match the attached memory.
- MAX_LOCK, 8, maximum consecutive port-1 grants under lock while port 0 is requesting.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pN_req  in  1  port N (N = 0, 1) request; held until granted.
- pN_we  in  1  1 = store, 0 = load.
- pN_addr  in  32  byte address.
- pN_wdata  in  32  store data, right-justified.
- pN_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- pN_unsigned  in  1  zero-extend load.
- pN_gnt  out  1  access accepted this cycle (combinational).
- pN_rvalid  out  1  response valid, one cycle after gnt.
- pN_rdata  out  32  registered load data; 0 for stores and errors.
- pN_err  out  1  qualifies pN_rvalid; access was rejected.
- p1_lock  in  1  port 1 requests to keep ownership on the next cycle.
- mem_addr  out  32  memory address.
- mem_dataW  out  32  memory write data.
- mem_MemRW  out  1  memory write enable.
- mem_MemSize  out  2  memory access size.
- mem_MemUnsigned  out  1  memory unsigned-load select.
- mem_dataR  in  32  combinational memory read data.

## Operation
- State registers:
  - last_gnt (1 bit);
  - lock_owner (1 bit);
  - lock_cnt (width clog2(MAX_LOCK+1));
  - per-port response registers.
- Arbitration, evaluated each cycle in this order:
  - If lock_owner = 1, p1_req = 1 and lock_cnt < MAX_LOCK: grant port 1.
  - Otherwise, if exactly one port is requesting: grant that port.
  - Otherwise, if both ports are requesting: grant the port that is not last_gnt.
  - Otherwise: no grant.
- Lock update at each clock edge:
  - lock_owner <= p1_gnt & p1_lock.
  - lock_cnt increments on a port-1 grant while lock_owner = 1 and p0_req = 1.
  - lock_cnt clears on any port-0 grant or when lock_owner falls.
  - When lock_cnt reaches MAX_LOCK with p0_req = 1, port 0 wins the next cycle and the count clears.
- last_gnt updates to the granted port on every grant and holds otherwise.
- Legality check on the candidate winner, done before any grant:
  - size = 11 is illegal.
  - Misalignment is illegal: half with addr[0] = 1, or word with addr[1:0] ≠ 00.
  - Out of range is illegal: addr + bytes > DEPTH_BYTES, computed as a 33-bit sum so no wrap.
- An illegal access is still granted and consumes the slot, but:
  - the memory sees MemRW = 0 and addr = 0;
  - the response has err = 1 and rdata = 0.
- Legal grant: the mem_* outputs mirror the winner's fields in the same cycle.
  - The store is written at the clock edge ending the grant cycle.
  - For a load, mem_dataR is captured into pN_rdata at that same edge.
- Idle cycle (no grant) drives mem_MemRW = 0, mem_addr = 0, mem_dataW = 0, mem_MemSize = 10, mem_MemUnsigned = 0.
- The memory's own range and extension logic is trusted; the arbiter never issues a write outside [0, DEPTH_BYTES).

## Timing
- Grant latency: 0 cycles. gnt asserts in the same cycle as req when the port wins.
- Response latency: 1 cycle. pN_rvalid is high for exactly one cycle after each pN_gnt, for both loads and stores.
- Back-to-back grants to one port produce back-to-back rvalid pulses.
- A requester may change its request fields only after the cycle in which gnt was high.
- Throughput: one access per cycle, with no bubble between ports.
- Reset values:
  - all rvalid, err = 0; all rdata = 0;
  - last_gnt = 1, so port 0 wins the first tie;
  - lock_owner = 0, lock_cnt = 0.
- Reset asserted in the same cycle as a grant: the grant is still combinationally visible, but the memory write is suppressed (mem_MemRW forced 0 while rst = 1) and no rvalid follows.
- Reset asserted while a response is pending drops that response.
- p1_lock is ignored when port 1 is not granted; a lock never blocks port 0 while p1_req = 0.

## Test plan
- Both ports store a word simultaneously out of reset: p0 at 0x10, p1 at 0x20. Required: p0_gnt in cycle 0, p1_gnt in cycle 1, one-cycle rvalid pulses in cycles 1 and 2, and both words read back correctly.
- Port 1 holds p1_lock and req for 20 cycles while p0_req is held, with MAX_LOCK = 8. Required: 8 consecutive p1 grants, then one p0 grant, then p1 resumes.
- p0 issues a half load at 0x3 (misaligned) and p1 a word load at 1022 (out of range). Required: each is granted, mem_MemRW = 0 and mem_addr = 0 in the grant cycle, and each response has err = 1, rdata = 0.
- Store byte 0x80 at 0x40, then load byte signed and unsigned from 0x40. Required: rdata 0xFFFFFF80 then 0x00000080, each valid one cycle after gnt.
- Assert rst in the cycle a p0 word store to 0x50 is granted. Required: mem_MemRW = 0, no rvalid, and memory at 0x50 unchanged; after reset the first tie goes to p0.
